// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and widths for the FPU write-back path
package fpu_pkg;

    localparam int FPU_FLAG_W = 5;
    localparam int FPU_DATA_W = 32;
    localparam int FPU_TAG_W  = 5;

    typedef enum logic [1:0] {
        SRC_ADD = 2'b00,
        SRC_MUL = 2'b01,
        SRC_DIV = 2'b10
    } fpu_src_e;

    typedef struct packed {
        logic [FPU_DATA_W-1:0] result;
        logic [FPU_FLAG_W-1:0] flags;
        logic [FPU_TAG_W-1:0]  tag;
    } fpu_wb_t;

endpackage

// File: rtl/fpu_rr_grant3.sv
// fpu_rr_grant3: three-way round-robin pick starting the scan at ptr
module fpu_rr_grant3
    import fpu_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output fpu_src_e   grant_idx
);

    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] idx;

    // scan ptr, ptr+1, ptr+2 (mod 3) and take the first valid channel
    always_comb begin
        p1        = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2        = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        idx       = valid[ptr] ? ptr : valid[p1] ? p1 : p2;
        grant     = (|valid) ? (3'b001 << idx) : 3'b000;
        grant_idx = fpu_src_e'(idx);
    end

endmodule

// File: rtl/fpu_result_arbiter.sv
// fpu_result_arbiter: round-robin merge of add/mul/div results into one registered write-back port
module fpu_result_arbiter
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = FPU_FLAG_W,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  add_valid,
    output logic                  add_ready,
    input  logic [DATA_WIDTH-1:0] add_result,
    input  logic [FLAG_WIDTH-1:0] add_flags,
    input  logic [TAG_WIDTH-1:0]  add_tag,
    input  logic                  mul_valid,
    output logic                  mul_ready,
    input  logic [DATA_WIDTH-1:0] mul_result,
    input  logic [FLAG_WIDTH-1:0] mul_flags,
    input  logic [TAG_WIDTH-1:0]  mul_tag,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic [DATA_WIDTH-1:0] div_result,
    input  logic [FLAG_WIDTH-1:0] div_flags,
    input  logic [TAG_WIDTH-1:0]  div_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [FLAG_WIDTH-1:0] out_flags,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [1:0]            out_src
);

    logic [1:0]            ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [1:0]            src_q, src_d;
    logic [2:0]            grant;
    fpu_src_e              gidx;
    logic [1:0]            g;
    logic                  can_load;
    logic                  fire;

    fpu_rr_grant3 u_grant (
        .valid     ({div_valid, mul_valid, add_valid}),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign can_load  = !valid_q | out_ready;
    assign add_ready = rst_n & can_load & grant[0];
    assign mul_ready = rst_n & can_load & grant[1];
    assign div_ready = rst_n & can_load & grant[2];

    // load the granted channel when the output slot frees, otherwise drain or hold
    always_comb begin
        g        = gidx;
        fire     = add_ready | mul_ready | div_ready;
        valid_d  = fire ? 1'b1 : (valid_q & out_ready) ? 1'b0 : valid_q;
        result_d = !fire ? result_q : (gidx == SRC_MUL) ? mul_result : (gidx == SRC_DIV) ? div_result : add_result;
        flags_d  = !fire ? flags_q : (gidx == SRC_MUL) ? mul_flags : (gidx == SRC_DIV) ? div_flags : add_flags;
        tag_d    = !fire ? tag_q : (gidx == SRC_MUL) ? mul_tag : (gidx == SRC_DIV) ? div_tag : add_tag;
        src_d    = fire ? g : src_q;
        ptr_d    = !fire ? ptr_q : (g == 2'd2) ? 2'd0 : g + 2'd1;
    end

    // output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 2'd0;
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            tag_q    <= '0;
            src_q    <= SRC_ADD;
        end else begin
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign out_tag    = tag_q;
    assign out_src    = src_q;

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// tb_fpu_result_arbiter: directed scoreboard bench for the write-back arbiter
module tb_fpu_result_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        out_ready;
    logic        add_ready, mul_ready, div_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_flags, out_tag;
    logic [1:0]  out_src;

    logic        vld  [3];
    logic        once [3];
    logic [31:0] res  [3];
    logic [4:0]  flg  [3];
    logic [4:0]  tg   [3];

    int total = 0;
    int bad   = 0;
    logic [43:0] q[$];

    always #5 clk = ~clk;

    fpu_result_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_valid  (vld[0]),
        .add_ready  (add_ready),
        .add_result (res[0]),
        .add_flags  (flg[0]),
        .add_tag    (tg[0]),
        .mul_valid  (vld[1]),
        .mul_ready  (mul_ready),
        .mul_result (res[1]),
        .mul_flags  (flg[1]),
        .mul_tag    (tg[1]),
        .div_valid  (vld[2]),
        .div_ready  (div_ready),
        .div_result (res[2]),
        .div_flags  (flg[2]),
        .div_tag    (tg[2]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .out_src    (out_src)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wb(input logic [1:0] s, input logic [31:0] r, input logic [4:0] f, input logic [4:0] t);
        q.push_back({s, r, f, t});
    endtask

    task automatic set_ch(input int i, input logic v, input logic o, input logic [31:0] r, input logic [4:0] f, input logic [4:0] t);
        vld[i]  = v;
        once[i] = o;
        res[i]  = r;
        flg[i]  = f;
        tg[i]   = t;
    endtask

    // one clock: sample handshakes before the edge, update producers after it
    task automatic cycle();
        logic [2:0] t;
        @(negedge clk);
        t = {vld[2] & div_ready, vld[1] & mul_ready, vld[0] & add_ready};
        check("ready_onehot", 32'($countones({div_ready, mul_ready, add_ready}) <= 1), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (t[i]) begin
                res[i] = res[i] + 32'd1;
                tg[i]  = tg[i] + 5'd1;
                if (once[i]) vld[i] = 1'b0;
            end
        end
    endtask

    // scoreboard monitor: every accepted output entry is matched against the queue
    always @(negedge clk) begin
        logic [43:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_entry", {30'd0, out_src}, 32'hFFFFFFFF);
            end else begin
                e = q.pop_front();
                check("wb_src",    {30'd0, out_src},   {30'd0, e[43:42]});
                check("wb_result", out_result,         e[41:10]);
                check("wb_flags",  {27'd0, out_flags}, {27'd0, e[9:5]});
                check("wb_tag",    {27'd0, out_tag},   {27'd0, e[4:0]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) set_ch(i, 1'b0, 1'b1, 32'd0, 5'd0, 5'd0);
        out_ready = 1'b1;
        #1 rst_n = 1'b0;

        // reset state with a pending add request
        set_ch(0, 1'b1, 1'b1, 32'h11110000, 5'd0, 5'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_add_ready", {31'd0, add_ready}, 32'd0);
        check("rst_mul_ready", {31'd0, mul_ready}, 32'd0);
        check("rst_div_ready", {31'd0, div_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_src",   {30'd0, out_src},   32'd0);
        check("rst_out_result", out_result,        32'd0);
        check("rst_out_tag",   {27'd0, out_tag},   32'd0);
        check("rst_out_flags", {27'd0, out_flags}, 32'd0);
        rst_n = 1'b1;
        expect_wb(2'b00, 32'h11110000, 5'd0, 5'd1);
        cycle();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);

        // single mul transfer, ptr now 1
        set_ch(1, 1'b1, 1'b1, 32'h3F800000, 5'b00001, 5'd7);
        expect_wb(2'b01, 32'h3F800000, 5'b00001, 5'd7);
        cycle();
        check("mul_valid", {31'd0, out_valid}, 32'd1);
        check("mul_src",   {30'd0, out_src},   32'd1);
        cycle();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // ptr=2 with add and mul pending: wrap to add, then mul
        set_ch(0, 1'b1, 1'b1, 32'h0000A0A0, 5'b00010, 5'd3);
        set_ch(1, 1'b1, 1'b1, 32'h0000B0B0, 5'b00000, 5'd4);
        expect_wb(2'b00, 32'h0000A0A0, 5'b00010, 5'd3);
        expect_wb(2'b01, 32'h0000B0B0, 5'b00000, 5'd4);
        cycle();
        check("wrap_src0", {30'd0, out_src}, 32'd0);
        cycle();
        check("wrap_src1", {30'd0, out_src}, 32'd1);
        cycle();

        // backpressure: div entry held while add waits
        set_ch(2, 1'b1, 1'b1, 32'h40490FDB, 5'b00001, 5'd9);
        expect_wb(2'b10, 32'h40490FDB, 5'b00001, 5'd9);
        cycle();
        out_ready = 1'b0;
        set_ch(0, 1'b1, 1'b1, 32'h3F000000, 5'b00000, 5'd12);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_add_ready", {31'd0, add_ready}, 32'd0);
            cycle();
            check("bp_valid",  {31'd0, out_valid}, 32'd1);
            check("bp_result", out_result,         32'h40490FDB);
            check("bp_src",    {30'd0, out_src},   32'd2);
            check("bp_tag",    {27'd0, out_tag},   32'd9);
        end
        out_ready = 1'b1;
        expect_wb(2'b00, 32'h3F000000, 5'b00000, 5'd12);
        cycle();
        check("bp_release_valid", {31'd0, out_valid}, 32'd1);
        check("bp_release_src",   {30'd0, out_src},   32'd0);

        // ptr=1: mul then div back to back
        set_ch(1, 1'b1, 1'b1, 32'h12345678, 5'b00100, 5'd13);
        set_ch(2, 1'b1, 1'b1, 32'h87654321, 5'b01000, 5'd14);
        expect_wb(2'b01, 32'h12345678, 5'b00100, 5'd13);
        expect_wb(2'b10, 32'h87654321, 5'b01000, 5'd14);
        cycle();
        cycle();

        // full rotation from ptr=0 with no bubbles
        set_ch(0, 1'b1, 1'b0, 32'hA0000000, 5'b10000, 5'd10);
        set_ch(1, 1'b1, 1'b0, 32'hB0000000, 5'b01000, 5'd20);
        set_ch(2, 1'b1, 1'b0, 32'hC0000000, 5'b00100, 5'd30);
        expect_wb(2'b00, 32'hA0000000, 5'b10000, 5'd10);
        expect_wb(2'b01, 32'hB0000000, 5'b01000, 5'd20);
        expect_wb(2'b10, 32'hC0000000, 5'b00100, 5'd30);
        expect_wb(2'b00, 32'hA0000001, 5'b10000, 5'd11);
        expect_wb(2'b01, 32'hB0000001, 5'b01000, 5'd21);
        expect_wb(2'b10, 32'hC0000001, 5'b00100, 5'd31);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rot_valid", {31'd0, out_valid}, 32'd1);
            check("rot_src",   {30'd0, out_src},   32'(k % 3));
        end
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        cycle();

        // stall with ptr=1, then asynchronous reset between edges
        set_ch(0, 1'b1, 1'b1, 32'hDEAD0000, 5'd0, 5'd15);
        cycle();
        out_ready = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  {31'd0, out_valid}, 32'd0);
        check("async_rst_result", out_result,         32'd0);
        set_ch(0, 1'b1, 1'b1, 32'h00000001, 5'd0, 5'd1);
        set_ch(1, 1'b1, 1'b1, 32'h00000002, 5'd0, 5'd2);
        set_ch(2, 1'b1, 1'b1, 32'h00000003, 5'd0, 5'd3);
        #1;
        check("async_rst_readies", {29'd0, div_ready, mul_ready, add_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_wb(2'b00, 32'h00000001, 5'd0, 5'd1);
        expect_wb(2'b01, 32'h00000002, 5'd0, 5'd2);
        expect_wb(2'b10, 32'h00000003, 5'd0, 5'd3);
        cycle();
        check("after_rst_src0", {30'd0, out_src}, 32'd0);
        cycle();
        check("after_rst_src1", {30'd0, out_src}, 32'd1);
        cycle();
        check("after_rst_src2", {30'd0, out_src}, 32'd2);
        repeat (2) cycle();
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
